// File: rtl/method_call_sequencer.sv
// method_call_sequencer: drives one req/busy/return method port of a
// Synthesijer-generated module. After an optional start delay it issues a
// call, waits for completion, captures the return value and reports
// pass / fail / timeout together with the call latency.
//
// Call handshake:
//   callee_req is held high until callee_busy is sampled high, which counts
//   as acceptance. The call completes on the first cycle busy is sampled low
//   after acceptance; callee_return is captured in that same cycle.
module method_call_sequencer #(
  parameter int unsigned          RET_WIDTH   = 32,
  parameter int unsigned          CNT_WIDTH   = 32,
  parameter int unsigned          START_DELAY = 100,
  parameter int unsigned          TIMEOUT     = 1000000,
  parameter logic [RET_WIDTH-1:0] EXPECTED    = RET_WIDTH'(1),
  parameter bit                   AUTO_START  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 callee_req,
  input  logic                 callee_busy,
  input  logic [RET_WIDTH-1:0] callee_return,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timed_out,
  output logic [RET_WIDTH-1:0] ret_value,
  output logic [CNT_WIDTH-1:0] latency,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Last counter value of each phase; DELAY_LAST is unused when START_DELAY = 0.
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(START_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST   = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 req_q, req_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 tmo_q, tmo_d;
  logic [RET_WIDTH-1:0] ret_q, ret_d;
  logic [CNT_WIDTH-1:0] lat_q, lat_d;
  // Pending automatic run; set by reset, consumed by the first launch.
  logic                 auto_q, auto_d;
  logic                 launch;

  // Saturating increment and launch request (start honoured in IDLE/DONE only).
  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    launch  = ((state_q == S_IDLE) && (start || auto_q)) ||
              ((state_q == S_DONE) && start);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    running_d = running_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    ret_d     = ret_q;
    lat_d     = lat_q;
    auto_d    = auto_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch) begin
          auto_d    = 1'b0;
          cnt_d     = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          tmo_d     = 1'b0;
          running_d = 1'b1;
          if (START_DELAY == 0) begin
            state_d = S_REQ;
            req_d   = 1'b1;
          end else begin
            state_d = S_DELAY;
          end
        end
      end

      S_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = S_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_REQ: begin
        cnt_d = cnt_inc;
        lat_d = cnt_inc;
        if (cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          req_d     = 1'b0;
          running_d = 1'b0;
          done_d    = 1'b1;
          tmo_d     = 1'b1;
          fail_d    = 1'b1;
          pass_d    = 1'b0;
        end else if (callee_busy) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_inc;
        lat_d = cnt_inc;
        // Completion is checked first so it wins over a coincident timeout.
        if (!callee_busy) begin
          state_d   = S_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          ret_d     = callee_return;
          pass_d    = (callee_return == EXPECTED);
          fail_d    = (callee_return != EXPECTED);
        end else if (cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          tmo_d     = 1'b1;
          fail_d    = 1'b1;
          pass_d    = 1'b0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        req_d     = 1'b0;
        running_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ret_q     <= '0;
      lat_q     <= '0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      running_q <= running_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      ret_q     <= ret_d;
      lat_q     <= lat_d;
      auto_q    <= auto_d;
    end
  end

  assign callee_req = req_q;
  assign running    = running_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timed_out  = tmo_q;
  assign ret_value  = ret_q;
  assign latency    = lat_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_method_call_sequencer.sv
// Bench for method_call_sequencer: three instances (auto start with a long
// delay, manual start with a short delay, manual start with no delay), each
// driven by a simple callee model whose busy pulse length, return value and
// "never answers" behaviour are chosen per call. A reference model predicts
// each call's outcome from the busy pulse length alone.
module tb_method_call_sequencer;

  localparam logic [31:0] EXP_VAL = 32'd1;
  int d_of [3] = '{100, 3, 0};
  int t_of [3] = '{50, 50, 20};

  logic        clk = 1'b0;
  logic        rst     [3];
  logic        start   [3];
  logic        req     [3];
  logic        busy    [3];
  logic [31:0] ret_in  [3];
  logic        running [3];
  logic        done    [3];
  logic        pass    [3];
  logic        fail    [3];
  logic        tmo     [3];
  logic [31:0] retv    [3];
  logic [31:0] lat     [3];
  logic [2:0]  dbg     [3];

  int          hold     [3];
  bit          never    [3];
  int          left     [3];
  logic [31:0] last_ret [3];

  int checks = 0;
  int errors = 0;

  // Clock.
  always #5 clk = ~clk;

  method_call_sequencer #(.START_DELAY(100), .TIMEOUT(50), .EXPECTED(32'd1), .AUTO_START(1'b1)) u_auto (
    .clk(clk), .reset(rst[0]), .start(start[0]), .callee_req(req[0]), .callee_busy(busy[0]),
    .callee_return(ret_in[0]), .running(running[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
    .timed_out(tmo[0]), .ret_value(retv[0]), .latency(lat[0]), .dbg_state(dbg[0]));

  method_call_sequencer #(.START_DELAY(3), .TIMEOUT(50), .EXPECTED(32'd1), .AUTO_START(1'b0)) u_man (
    .clk(clk), .reset(rst[1]), .start(start[1]), .callee_req(req[1]), .callee_busy(busy[1]),
    .callee_return(ret_in[1]), .running(running[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
    .timed_out(tmo[1]), .ret_value(retv[1]), .latency(lat[1]), .dbg_state(dbg[1]));

  method_call_sequencer #(.START_DELAY(0), .TIMEOUT(20), .EXPECTED(32'd1), .AUTO_START(1'b0)) u_zero (
    .clk(clk), .reset(rst[2]), .start(start[2]), .callee_req(req[2]), .callee_busy(busy[2]),
    .callee_return(ret_in[2]), .running(running[2]), .done(done[2]), .pass(pass[2]), .fail(fail[2]),
    .timed_out(tmo[2]), .ret_value(retv[2]), .latency(lat[2]), .dbg_state(dbg[2]));

  // Callee models: busy rises one cycle after req is seen and stays high
  // for hold[k] sampled cycles; a "never" callee ignores req entirely.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        busy[k] <= 1'b0;
        left[k] <= 0;
      end else if (busy[k]) begin
        if (left[k] <= 1) busy[k] <= 1'b0;
        else              left[k] <= left[k] - 1;
      end else if (req[k] && !never[k]) begin
        busy[k] <= 1'b1;
        left[k] <= hold[k];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the callee of instance k to be idle.
  task automatic wait_callee_idle(input int k);
    int n;
    n = 0;
    while (busy[k] && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("callee_idle", {31'd0, busy[k]}, 32'd0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
  endtask

  // One call on instance k, triggered by reset release (auto start) or by a
  // start pulse. Optional poke: a start pulse while the call is in WAIT.
  task automatic run(input int k, input bit by_reset, input int h, input bit nv,
                     input logic [31:0] rv, input bit poke);
    int n, req_edge, done_edge, req_hi, lat_exp, d, t;
    bit complete, pass_exp;
    logic [31:0] ret_exp;
    d = d_of[k];
    t = t_of[k];
    if (by_reset) begin
      rst[k] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      hold[k] = h; never[k] = nv; ret_in[k] = rv;
      last_ret[k] = '0;
      rst[k] = 1'b0;
    end else begin
      wait_callee_idle(k);
      hold[k] = h; never[k] = nv; ret_in[k] = rv;
      start[k] = 1'b1;
    end

    // Reference model: a call answered with a busy pulse of h cycles
    // completes h+2 cycles after req rises, unless that exceeds TIMEOUT.
    complete = !nv && (h + 2 <= t);
    lat_exp  = complete ? h + 2 : t;
    ret_exp  = complete ? rv : last_ret[k];
    pass_exp = complete && (rv == EXP_VAL);

    n = 0; req_edge = -1; done_edge = -1; req_hi = 0;
    while (done_edge < 0 && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start[k] = 1'b0;
      if (n == 1) begin
        check("launch_running", {31'd0, running[k]}, 32'd1);
        check("launch_flags_clear", {28'd0, done[k], pass[k], fail[k], tmo[k]}, 32'd0);
      end
      if (req[k]) begin
        req_hi++;
        if (req_edge < 0) req_edge = n;
      end
      if (done[k]) done_edge = n;
      if (poke && req_edge > 0 && n == req_edge + 3) start[k] = 1'b1;
    end
    check("done_seen", {31'd0, done_edge >= 0}, 32'd1);
    check("req_rise_edge", req_edge, d + 1);
    check("req_high_cycles", req_hi, nv ? t : 2);
    check("done_edge", done_edge, d + 1 + lat_exp);
    check("pass", {31'd0, pass[k]}, {31'd0, pass_exp});
    check("fail", {31'd0, fail[k]}, {31'd0, !pass_exp});
    check("timed_out", {31'd0, tmo[k]}, {31'd0, !complete});
    check("ret_value", retv[k], ret_exp);
    check("latency", lat[k], lat_exp);
    check("req_low_in_done", {30'd0, req[k], running[k]}, 32'd0);
    last_ret[k] = ret_exp;
    // Flags stay held while DONE with no start.
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("done_held", {29'd0, done[k], pass[k], tmo[k]}, {29'd0, 1'b1, pass_exp, !complete});
  endtask

  initial begin
    int n, quiet;
    bit seen_hi;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; ret_in[k] = '0;
      hold[k] = 5; never[k] = 1'b0; last_ret[k] = '0;
    end

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_ctrl", {27'd0, req[k], running[k], done[k], pass[k], fail[k]}, 32'd0);
      check("rst_tmo", {31'd0, tmo[k]}, 32'd0);
      check("rst_ret", retv[k], 32'd0);
      check("rst_lat", lat[k], 32'd0);
    end

    // Manual-start instances stay quiet without a start pulse.
    rst[1] = 1'b0; rst[2] = 1'b0;
    quiet = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (req[1] || running[1] || done[1] || req[2] || running[2] || done[2]) quiet++;
    end
    check("no_auto_activity", quiet, 0);

    // Auto start: basic pass, return mismatch, never-busy timeout,
    // completion on the timeout cycle, timeout while in WAIT.
    run(0, 1'b1, 5, 1'b0, 32'd1, 1'b0);
    run(0, 1'b1, 5, 1'b0, 32'd0, 1'b0);
    run(0, 1'b1, 5, 1'b1, 32'd1, 1'b0);
    run(0, 1'b1, 48, 1'b0, 32'd1, 1'b0);
    run(0, 1'b1, 49, 1'b0, 32'd1, 1'b0);

    // Reset three cycles into WAIT aborts the call.
    rst[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    hold[0] = 20; never[0] = 1'b0; ret_in[0] = 32'd1;
    rst[0] = 1'b0;
    n = 0; seen_hi = 1'b0;
    while (n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (req[0]) seen_hi = 1'b1;
      else if (seen_hi) break;
    end
    check("abort_reached_wait", {31'd0, seen_hi}, 32'd1);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("abort_running_before", {30'd0, running[0], done[0]}, 32'd2);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ctrl", {27'd0, req[0], running[0], done[0], pass[0], fail[0]}, 32'd0);
    check("abort_tmo", {31'd0, tmo[0]}, 32'd0);
    check("abort_ret", retv[0], 32'd0);
    run(0, 1'b1, 5, 1'b0, 32'd1, 1'b0);

    // Manual start: pass, rerun from DONE with a start poked into WAIT,
    // then a timeout that must leave ret_value as captured before.
    run(1, 1'b0, 6, 1'b0, 32'd1, 1'b0);
    run(1, 1'b0, 6, 1'b0, 32'h0000_0007, 1'b1);
    run(1, 1'b0, 4, 1'b0, 32'd1, 1'b0);
    run(1, 1'b0, 4, 1'b1, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 8; i++)
      run(1, 1'b0, $urandom_range(1, 60), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom, $urandom_range(0, 1) == 1);

    // Zero start delay: REQ entered straight from IDLE/DONE.
    run(2, 1'b0, 3, 1'b0, 32'd1, 1'b0);
    for (int i = 0; i < 6; i++)
      run(2, 1'b0, $urandom_range(1, 25), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
